// File: rtl/fifo_tx_scheduler.sv
// fifo_tx_scheduler: sits between the synq_fifo read port and uart_tx.
// It reads one byte at a time, launches it with a one-cycle DV strobe,
// waits for Tx_Done, inserts an optional idle gap, counts completed bytes
// and raises a sticky error if the transmitter never reports Done.
// Optional feature macro: TX_SCHED_CTS_EN adds i_Cts_n (active-low
// clear-to-send) which gates new FIFO reads.
// Handshake: o_rd_en is a one-cycle pulse issued only from IDLE, so at most
// one byte is ever in flight; o_Tx_DV is a one-cycle launch pulse with
// o_Tx_Byte valid in the same cycle and held until the next capture.
module fifo_tx_scheduler #(
  parameter int RD_LATENCY    = 1,
  parameter int IDLE_GAP_CLKS = 0,
  parameter int TIMEOUT_CLKS  = 20000,
  parameter int CNT_W         = 16
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  input  logic             i_f_empty,
  input  logic [7:0]       i_rd_data,
  output logic             o_rd_en,
  input  logic             i_Tx_Active,
  input  logic             i_Tx_Done,
`ifdef TX_SCHED_CTS_EN
  input  logic             i_Cts_n,
`endif
  output logic             o_Tx_DV,
  output logic [7:0]       o_Tx_Byte,
  output logic             o_Busy,
  output logic [CNT_W-1:0] o_Byte_Cnt,
  output logic             o_Err
);

  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam int GAP_W = (IDLE_GAP_CLKS > 1) ? $clog2(IDLE_GAP_CLKS) : 1;
  localparam logic [1:0]       LAT_INIT = 2'(RD_LATENCY);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IDLE_GAP_CLKS > 0) ? IDLE_GAP_CLKS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_WAIT   = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        lat_q, lat_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              rd_en_q, rd_en_d;
  logic              dv_q, dv_d;
  logic [7:0]        byte_q, byte_d;
  logic              busy_q;
  logic              cts_ok;

`ifdef TX_SCHED_CTS_EN
  logic [1:0] cts_sync_q;

  // Two-flop synchroniser for the asynchronous CTS line; resets to "not clear".
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) cts_sync_q <= 2'b11;
    else          cts_sync_q <= {cts_sync_q[0], i_Cts_n};
  end

  assign cts_ok = ~cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  // State, counters and all outputs are registered here.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      to_q    <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      dv_q    <= 1'b0;
      byte_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_en_q <= rd_en_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Next-state logic; strobes default low so they last exactly one cycle.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    to_d    = to_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_en_d = 1'b0;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    case (state_q)
      S_IDLE: begin
        if (!i_f_empty && !i_Tx_Active && cts_ok) begin
          rd_en_d = 1'b1;
          lat_d   = LAT_INIT;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // The o_rd_en cycle is the first RD_WAIT cycle; data is sampled at
        // the end of the cycle lying RD_LATENCY cycles after it.
        if (lat_q == 2'd0) begin
          byte_d  = i_rd_data;
          dv_d    = 1'b1;
          to_d    = '0;
          state_d = S_LAUNCH;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      S_LAUNCH: begin
        // The launch cycle is the first clock counted toward the timeout.
        to_d    = to_q + TO_W'(1);
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_Tx_Done) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (IDLE_GAP_CLKS > 0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_rd_en    = rd_en_q;
  assign o_Tx_DV    = dv_q;
  assign o_Tx_Byte  = byte_q;
  assign o_Busy     = busy_q;
  assign o_Byte_Cnt = cnt_q;
  assign o_Err      = err_q;

endmodule

// File: tb/tb_fifo_tx_scheduler.sv
// Directed bench for fifo_tx_scheduler with a behavioural FIFO read port
// (data valid only in the RD_LATENCY cycle) and a uart_tx model that
// returns Done a fixed number of clocks after DV.
module tb_fifo_tx_scheduler;

  localparam int RD_LAT   = 2;
  localparam int GAP      = 5;
  localparam int TMO      = 120;
  localparam int CW       = 4;
  localparam int DONE_DLY = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          f_empty = 1'b1;
  logic [7:0]    rd_data = 8'h00;
  logic          rd_en;
  logic          tx_active = 1'b0;
  logic          tx_done = 1'b0;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          busy;
  logic [CW-1:0] byte_cnt;
  logic          err;
`ifdef TX_SCHED_CTS_EN
  logic          cts_n = 1'b0;
`endif

  fifo_tx_scheduler #(
    .RD_LATENCY    (RD_LAT),
    .IDLE_GAP_CLKS (GAP),
    .TIMEOUT_CLKS  (TMO),
    .CNT_W         (CW)
  ) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_f_empty   (f_empty),
    .i_rd_data   (rd_data),
    .o_rd_en     (rd_en),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
`ifdef TX_SCHED_CTS_EN
    .i_Cts_n     (cts_n),
`endif
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .o_Busy      (busy),
    .o_Byte_Cnt  (byte_cnt),
    .o_Err       (err)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] fifo_q[$];
  int rd_cyc_q[$], dv_cyc_q[$], cnt_cyc_q[$], err_cyc_q[$];
  int n_rd = 0;
  int n_dv = 0;
  bit tx_hang = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -100000;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic clear_logs();
    rd_cyc_q.delete();
    dv_cyc_q.delete();
    cnt_cyc_q.delete();
    err_cyc_q.delete();
  endtask

  task automatic wait_cnt_events(input int target, input int budget, input string tag);
    int n = 0;
    while (cnt_cyc_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(tag, cnt_cyc_q.size(), target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_dv"},    tx_dv, 0);
    check({tag, "_byte"},  tx_byte, 8'h00);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_cnt"},   byte_cnt, 0);
    check({tag, "_err"},   err, 0);
  endtask

  // ---------------- FIFO read-port model ----------------
  // Data is correct only in the cycle RD_LAT after the o_rd_en cycle;
  // any other cycle shows the inverted byte so a mistimed capture is visible.
  logic [7:0] pend = 8'h00;
  int age = 99;
  always @(negedge clk) begin
    if (rd_en && fifo_q.size() > 0) begin
      pend = fifo_q.pop_front();
      age  = 0;
    end else if (age < 99) begin
      age++;
    end
    rd_data = (age == RD_LAT) ? pend : ~pend;
    f_empty = (fifo_q.size() == 0);
  end

  // ---------------- uart_tx model ----------------
  int tx_timer = 0;
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!rst_n) tx_timer = 0;
    else if (tx_dv) begin
      if (!tx_hang) tx_timer = DONE_DLY;
    end else if (tx_timer > 0) begin
      tx_timer--;
      if (tx_timer == 0) tx_done = 1'b1;
    end
    tx_active = (tx_timer > 0);
  end

  // ---------------- monitor ----------------
  logic [CW-1:0] prev_cnt = '0;
  logic prev_err = 1'b0;
  bit inflight = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cnt = '0;
      prev_err = 1'b0;
      inflight = 1'b0;
    end else begin
      if (rd_en) begin
        n_rd++;
        rd_cyc_q.push_back(cyc);
        check("rd_single_outstanding", inflight, 0);
        inflight = 1'b1;
      end else if (!busy) begin
        inflight = 1'b0;
      end
      if (tx_dv) begin
        n_dv++;
        dv_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("dv_unexpected", 1, 0);
        else check("dv_byte", tx_byte, exp_q.pop_front());
      end
      if (byte_cnt != prev_cnt) cnt_cyc_q.push_back(cyc);
      prev_cnt = byte_cnt;
      if (err && !prev_err) err_cyc_q.push_back(cyc);
      prev_err = err;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n0;
    int n;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Three bytes back to back.
    clear_logs();
    push(8'hA5); push(8'h3C); push(8'hFF);
    wait_cnt_events(3, 2000, "t1_done_events");
    check("t1_cnt", byte_cnt, 3);
    check("t1_rd_pulses", n_rd, 3);
    check("t1_dv_pulses", n_dv, 3);
    check("t1_exp_drained", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      check("t1_rd_to_dv", at(dv_cyc_q, i) - at(rd_cyc_q, i), RD_LAT + 1);
      check("t1_dv_to_cnt", at(cnt_cyc_q, i) - at(dv_cyc_q, i), DONE_DLY + 1);
    end
    for (int i = 0; i < 2; i++)
      check("t1_done_to_next_rd", at(rd_cyc_q, i + 1) - at(cnt_cyc_q, i), GAP + 1);

    // Empty FIFO idle window.
    n0 = n_rd;
    repeat (200) @(negedge clk);
    check("idle_no_rd", n_rd, n0);
    check("idle_busy", busy, 0);

    // Transmitter never answers.
    clear_logs();
    tx_hang = 1'b1;
    push(8'h11);
    n = 0;
    while (!err && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("t3_err_set", err, 1);
    check("t3_err_delay", at(err_cyc_q, 0) - at(dv_cyc_q, 0), TMO);
    check("t3_cnt_held", byte_cnt, 3);
    check("t3_busy_after_err", busy, 0);
    tx_hang = 1'b0;
    push(8'h22);
    wait_cnt_events(1, 2000, "t3_next_done");
    check("t3_next_cnt", byte_cnt, 4);
    check("t3_next_rd", n_rd, n0 + 2);
    check("t3_err_sticky", err, 1);

    // Asynchronous reset in the middle of WAIT_DONE.
    push(8'h33);
    n = 0;
    while (!tx_dv && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_launch_seen", tx_dv, 1);
    repeat (10) @(negedge clk);
    check("t4_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t4_async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    n0 = n_rd;
    repeat (20) @(negedge clk);
    check("t4_no_reread", n_rd, n0);
    push(8'h44);
    wait_cnt_events(1, 2000, "t4_after_reset_done");
    check("t4_after_reset_cnt", byte_cnt, 1);
    check("t4_after_reset_rd", n_rd, n0 + 1);

    // Counter wrap: 17 bytes from zero ends at 1 with a 4-bit counter.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    n0 = n_dv;
    for (int i = 0; i < 17; i++) push(8'(i * 37 + 5));
    wait_cnt_events(17, 17 * 140, "t5_done_events");
    check("t5_cnt_wrap", byte_cnt, 1);
    check("t5_dv_pulses", n_dv - n0, 17);
    check("t5_exp_drained", exp_q.size(), 0);

`ifdef TX_SCHED_CTS_EN
    // Clear-to-send gating.
    cts_n = 1'b1;
    repeat (5) @(negedge clk);
    clear_logs();
    n0 = n_rd;
    push(8'hC1); push(8'hC2);
    repeat (40) @(negedge clk);
    check("cts_blocked", n_rd, n0);
    cts_n = 1'b0;
    n = 0;
    while (!rd_en && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("cts_rd_latency", n, 3);
    n = 0;
    while (!tx_dv && n < 20) begin
      @(negedge clk);
      n++;
    end
    cts_n = 1'b1;
    wait_cnt_events(1, 400, "cts_frame1_done");
    repeat (200) @(negedge clk);
    check("cts_no_second_rd", n_rd, n0 + 1);
    cts_n = 1'b0;
    wait_cnt_events(2, 400, "cts_frame2_done");
    check("cts_second_rd", n_rd, n0 + 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_tx_scheduler.md
Name: fifo_tx_scheduler

Overview:
- Downstream stage between synq_fifo read port and uart_tx.
- Drains the FIFO one byte at a time and launches each byte to the transmitter with a single-cycle DV pulse.
- Waits for Tx_Done before the next read, enforces a programmable inter-byte gap, counts sent bytes, and flags a stuck transmitter.
- Replaces direct rd_en→i_Tx_DV wiring so no FIFO read occurs while uart_tx is busy.

Parameters:
- RD_LATENCY, 1, cycles from o_rd_en high to i_rd_data valid; legal values 1..3.
- IDLE_GAP_CLKS, 0, idle clocks inserted after each Tx_Done before the next read; 0 means no gap.
- TIMEOUT_CLKS, 20000, max clocks in WAIT_DONE before error; must exceed one UART frame (10*CLKS_PER_BIT).
- CNT_W, 16, width of sent-byte counter.

Ports:
- i_Clock  in  1  system clock, rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_f_empty  in  1  FIFO empty flag.
- i_rd_data  in  8  FIFO read data.
- o_rd_en  out  1  FIFO read strobe, one-cycle pulse.
- i_Tx_Active  in  1  uart_tx busy.
- i_Tx_Done  in  1  uart_tx frame-complete pulse.
- o_Tx_DV  out  1  one-cycle launch strobe to uart_tx.
- o_Tx_Byte  out  8  byte to transmit, held stable from launch until the next capture.
- o_Busy  out  1  high in any state other than IDLE.
- o_Byte_Cnt  out  CNT_W  bytes completed (Tx_Done seen); wraps modulo 2^CNT_W.
- o_Err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): state=IDLE; o_rd_en=0, o_Tx_DV=0, o_Tx_Byte=8'h00, o_Busy=0, o_Byte_Cnt=0, o_Err=0; all internal counters cleared. Reset mid-frame abandons the byte; no FIFO re-read occurs.
- All outputs are registered.
- FSM states: IDLE, RD_WAIT, LAUNCH, WAIT_DONE, GAP.
- IDLE:
  - If !i_f_empty && !i_Tx_Active (and CTS permits, see Optional Feature): assert o_rd_en for exactly one cycle, load lat_cnt=RD_LATENCY, go RD_WAIT.
  - Otherwise hold.
- RD_WAIT:
  - Decrement lat_cnt each cycle.
  - When it reaches 0, capture i_rd_data into o_Tx_Byte and go LAUNCH.
  - The captured byte is the one present RD_LATENCY cycles after the o_rd_en cycle.
- LAUNCH: o_Tx_DV=1 for one cycle; clear timeout counter; go WAIT_DONE.
- WAIT_DONE:
  - On i_Tx_Done: o_Byte_Cnt+=1, then go GAP if IDLE_GAP_CLKS>0, else IDLE.
  - If the timeout counter reaches TIMEOUT_CLKS first: set o_Err=1 and go IDLE without incrementing o_Byte_Cnt.
  - If i_Tx_Done and the timeout coincide, Done wins.
- GAP: count IDLE_GAP_CLKS cycles, then IDLE.
- Throughput: read-to-DV latency = RD_LATENCY+1 cycles. The earliest next o_rd_en is 1 cycle after the Tx_Done cycle when gap=0, or IDLE_GAP_CLKS+1 cycles otherwise.
- Single outstanding byte:
  - o_rd_en never asserts outside IDLE, so at most one byte is in flight.
  - FIFO empty going high after a read does not cancel the in-flight byte.
- i_Tx_Done seen outside WAIT_DONE is ignored.
- o_Busy = (state != IDLE).

Optional Feature:
- Macro: TX_SCHED_CTS_EN.
- Defined:
  - Adds input port i_Cts_n (1 bit, active-low clear-to-send, asynchronous source) after i_Tx_Done.
  - i_Cts_n is synchronised through 2 flops inside the block.
  - The IDLE read condition additionally requires synchronised CTS low.
  - Deasserting CTS mid-frame does not abort: the current byte completes and the FSM then holds in IDLE.
- Not defined: no port; CTS is treated as always asserted.

Test Plan:
- Reset then push 3 bytes 8'hA5,8'h3C,8'hFF into FIFO, uart_tx model returns Done 100 clks after DV -> exactly 3 o_rd_en pulses and 3 o_Tx_DV pulses, bytes in order A5,3C,FF; o_Byte_Cnt=3; each o_rd_en occurs only after the prior Done.
- RD_LATENCY=2, IDLE_GAP_CLKS=5, 2 bytes -> DV 3 cycles after each o_rd_en; second o_rd_en exactly 6 cycles after first Done.
- Tx model never returns Done, TIMEOUT_CLKS=50 -> o_Err rises 50 clks after DV; o_Byte_Cnt stays 0; a new read occurs when FIFO non-empty; o_Err stays 1.
- Assert i_Rst_n low mid-WAIT_DONE -> all outputs at reset values immediately (async); after release, next FIFO byte is read normally.
- CNT_W=4, send 17 bytes -> o_Byte_Cnt=1 (wrap); FIFO empty throughout a 200-cycle idle window -> no o_rd_en.
- With TX_SCHED_CTS_EN, hold i_Cts_n=1 with 2 bytes queued -> no o_rd_en; drop to 0 -> o_rd_en within 3 cycles; raise during frame 1 -> frame 1 completes, no second read until CTS is low again.
